// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a credit-limited prefetch queue in front of a
// variable-latency instruction memory; supports downstream freeze and branch redirect.
module if_prefetch_stage #(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter int                FIFO_DEPTH = 4,
   parameter int                PC_STEP    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              out_valid,
   output logic [INST_W-1:0] instruction,
   output logic [ADDR_W-1:0] pc
);

   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam int                CNT_W     = PTR_W + 1;
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
   localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

   logic [INST_W-1:0] word_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count, outstanding, discard;
   logic [ADDR_W-1:0] fetch_pc, resp_pc;
   logic [CNT_W:0]    credits_used;
   logic              accept, push, pop;

   // Live (non-discarded) fetches in flight plus queued words bound the next request,
   // so every accepted request is guaranteed a FIFO slot when it returns.
   always_comb begin
      credits_used = {1'b0, count} + {1'b0, outstanding} - {1'b0, discard};
      imem_req     = !rst && !branch_taken && (credits_used < DEPTH_EXT);
      accept       = imem_req && imem_ready;
      push         = imem_rvalid && (discard == '0) && !branch_taken;
      pop          = out_valid && !freeze && !branch_taken;
   end

   assign imem_addr   = fetch_pc;
   assign out_valid   = (count != '0);
   assign instruction = out_valid ? word_mem[rd_ptr] : '0;
   assign pc          = out_valid ? pc_mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
      end else if (branch_taken) begin
         // Everything still in flight after this edge belongs to the old stream.
         fetch_pc    <= branch_addr;
         resp_pc     <= branch_addr;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= outstanding - CNT_W'(imem_rvalid);
         discard     <= outstanding - CNT_W'(imem_rvalid);
      end else begin
         if (accept) begin
            fetch_pc <= fetch_pc + STEP;
         end
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_rvalid);
         if (imem_rvalid && (discard != '0)) begin
            discard <= discard - CNT_W'(1);
         end
         if (push) begin
            wr_ptr  <= wr_ptr + PTR_W'(1);
            resp_pc <= resp_pc + STEP;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         word_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]   <= resp_pc + STEP;
      end
   end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Self-checking bench for if_prefetch_stage: in-order memory model with random latency/ready
// and a stream-level reference model of expected fetch addresses and delivered words.
module tb_if_prefetch_stage;

   localparam int          ADDR_W = 32;
   localparam int          INST_W = 32;
   localparam int          DEPTH  = 4;
   localparam int          STEP   = 4;
   localparam logic [31:0] RPC    = 32'h0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              freeze = 1'b0;
   logic              branch_taken = 1'b0;
   logic [ADDR_W-1:0] branch_addr = '0;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ready = 1'b0;
   logic              imem_rvalid = 1'b0;
   logic [INST_W-1:0] imem_rdata = '0;
   logic              out_valid;
   logic [INST_W-1:0] instruction;
   logic [ADDR_W-1:0] pc;

   if_prefetch_stage #(
      .ADDR_W(ADDR_W), .INST_W(INST_W), .FIFO_DEPTH(DEPTH), .PC_STEP(STEP), .RESET_PC(RPC)
   ) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
      .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .instruction(instruction), .pc(pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          gen;
      logic [31:0] addr;
      int          due;
   } req_t;

   logic [31:0] mem [256];
   req_t        pend[$];
   int          tests = 0, fails = 0;
   int          cyc = 0, gen = 0, last_due = 0;
   int          lat_min = 1, lat_max = 1, ready_pct = 100;
   logic [31:0] exp_fetch = RPC, exp_head = RPC;
   int          fifo_n = 0, pops = 0;
   int          acc_seen = 0, first_acc_cyc = 0, valid_seen = 0, first_valid_cyc = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;

   // Instruction memory: in-order responses, latency >= 1 cycle after acceptance
   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
         pend.delete();
         imem_rvalid = 1'b0;
         imem_ready  = 1'b0;
         imem_rdata  = '0;
         last_due    = 0;
      end else begin
         imem_ready = (int'($urandom_range(0, 99)) < ready_pct);
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem[pend[0].addr[9:2]];
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
         end
      end
   end

   // Stream reference model: what the next edge must do, checked at the negedge before it
   int          m_live, m_due;
   logic        m_req, m_valid, m_resp_live, m_acc, m_pop;
   req_t        m_ent;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         tests++;
         if (out_valid !== 1'b0 || imem_req !== 1'b0 || instruction !== '0 || pc !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b req=%b inst=%h pc=%h, want all 0",
                     out_valid, imem_req, instruction, pc);
         end
         exp_fetch = RPC; exp_head = RPC; fifo_n = 0; gen++; pend.delete();
         acc_seen = 0; valid_seen = 0; prev_stall = 1'b0; last_due = 0;
      end else begin
         m_live = int'((exp_fetch - exp_head) / STEP);
         m_req  = !branch_taken && (m_live < DEPTH);
         tests++;
         if (imem_req !== m_req) begin
            fails++;
            $display("FAIL imem_req: got %b want %b (live=%0d) t=%0t", imem_req, m_req, m_live, $time);
         end
         if (m_req) begin
            tests++;
            if (imem_addr !== exp_fetch) begin
               fails++;
               $display("FAIL imem_addr: got %h want %h t=%0t", imem_addr, exp_fetch, $time);
            end
         end
         if (prev_stall && !branch_taken) begin
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
               fails++;
               $display("FAIL addr_stable: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, prev_addr);
            end
         end
         m_valid = (fifo_n > 0);
         tests++;
         if (out_valid !== m_valid) begin
            fails++;
            $display("FAIL out_valid: got %b want %b t=%0t", out_valid, m_valid, $time);
         end
         tests++;
         if (m_valid) begin
            if (instruction !== mem[exp_head[9:2]] || pc !== exp_head + STEP) begin
               fails++;
               $display("FAIL head: got inst=%h pc=%h want inst=%h pc=%h t=%0t",
                        instruction, pc, mem[exp_head[9:2]], exp_head + STEP, $time);
            end
         end else if (instruction !== '0 || pc !== '0) begin
            fails++;
            $display("FAIL bubble: got inst=%h pc=%h want 0 0", instruction, pc);
         end
         if (out_valid === 1'b1 && valid_seen == 0) begin
            valid_seen = 1; first_valid_cyc = cyc;
         end
         m_resp_live = 1'b0;
         if (imem_rvalid && pend.size() > 0) begin
            m_ent = pend.pop_front();
            m_resp_live = (m_ent.gen == gen);
         end
         if (branch_taken) begin
            gen++;
            exp_fetch  = branch_addr;
            exp_head   = branch_addr;
            fifo_n     = 0;
            prev_stall = 1'b0;
         end else begin
            m_acc = m_req && (imem_ready === 1'b1);
            prev_stall = m_req && !m_acc;
            prev_addr  = exp_fetch;
            if (m_acc) begin
               if (acc_seen == 0) begin
                  acc_seen = 1; first_acc_cyc = cyc;
               end
               m_due = cyc + int'($urandom_range(lat_min, lat_max));
               if (m_due <= last_due) m_due = last_due + 1;
               last_due = m_due;
               m_ent.gen = gen; m_ent.addr = exp_fetch; m_ent.due = m_due;
               pend.push_back(m_ent);
               exp_fetch = exp_fetch + STEP;
            end
            m_pop = (fifo_n > 0) && !freeze;
            if (m_resp_live) fifo_n++;
            if (m_pop) begin
               fifo_n--; exp_head = exp_head + STEP; pops++;
            end
         end
      end
   end

   task automatic wait_valid(input string name, input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (out_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         tests++; fails++;
         $display("FAIL %s_timeout: out_valid never rose within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if (out_valid !== 1'b0 || imem_req !== 1'b0 || instruction !== '0 || pc !== '0) begin
         fails++;
         $display("FAIL test_reset: got valid=%b req=%b inst=%h pc=%h want 0", out_valid, imem_req, instruction, pc);
      end
      #51;
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      bit found;
      wait_valid("sequential", 50, found);
      if (found) begin
         tests++;
         if (pc !== RPC + STEP || instruction !== mem[RPC[9:2]]) begin
            fails++;
            $display("FAIL seq_first: got pc=%h inst=%h want pc=%h inst=%h", pc, instruction, RPC + STEP, mem[RPC[9:2]]);
         end
         tests++;
         if (first_valid_cyc !== first_acc_cyc + 2) begin
            fails++;
            $display("FAIL seq_latency: got valid at cycle %0d want %0d", first_valid_cyc, first_acc_cyc + 2);
         end
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic test_freeze();
      logic [31:0] hold_i, hold_pc;
      logic        hold_v;
      @(posedge clk); #2;
      freeze = 1'b1;
      @(negedge clk); #1;
      hold_i = instruction; hold_pc = pc; hold_v = out_valid;
      repeat (10) begin
         @(negedge clk); #1;
         tests++;
         if (instruction !== hold_i || pc !== hold_pc || out_valid !== hold_v) begin
            fails++;
            $display("FAIL freeze_hold: got v=%b inst=%h pc=%h want v=%b inst=%h pc=%h",
                     out_valid, instruction, pc, hold_v, hold_i, hold_pc);
         end
      end
      tests++;
      if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL freeze_full: got req=%b valid=%b want req=0 valid=1", imem_req, out_valid);
      end
      @(posedge clk); #2;
      freeze = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk); #1;
         tests++;
         if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL freeze_drain: got valid=%b want 1 at drain slot %0d", out_valid, i);
         end
      end
   endtask

   task automatic test_branch();
      int  live_pend;
      bit  found;
      lat_min = 3; lat_max = 3;
      repeat (10) @(negedge clk);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #2;
         live_pend = 0;
         foreach (pend[k]) if (pend[k].gen == gen) live_pend++;
         if (live_pend >= 2) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         tests++; fails++;
         $display("FAIL branch_setup: got %0d outstanding want >=2", live_pend);
      end
      branch_taken = 1'b1;
      branch_addr  = 32'h40;
      @(negedge clk); #1;
      tests++;
      if (imem_req !== 1'b0) begin
         fails++;
         $display("FAIL branch_req: got %b want 0", imem_req);
      end
      @(posedge clk); #2;
      branch_taken = 1'b0;
      @(negedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         fails++;
         $display("FAIL branch_next: got v=%b req=%b addr=%h want v=0 req=1 addr=00000040", out_valid, imem_req, imem_addr);
      end
      wait_valid("branch", 30, found);
      if (found) begin
         tests++;
         if (instruction !== mem[16] || pc !== 32'h44) begin
            fails++;
            $display("FAIL branch_target: got inst=%h pc=%h want inst=%h pc=00000044", instruction, pc, mem[16]);
         end
      end
   endtask

   task automatic test_branch_collision();
      logic [31:0] baddr;
      bit          found;
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #2;
         if (imem_rvalid === 1'b1 && out_valid === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         tests++; fails++;
         $display("FAIL collision_setup: got no rvalid cycle within 50, want one");
      end
      baddr        = 32'($urandom_range(0, 255)) << 2;
      branch_addr  = baddr;
      branch_taken = 1'b1;
      freeze       = 1'b1;
      @(negedge clk); #1;
      tests++;
      if (imem_req !== 1'b0) begin
         fails++;
         $display("FAIL collision_req: got %b want 0", imem_req);
      end
      @(posedge clk); #2;
      branch_taken = 1'b0;
      freeze       = 1'b0;
      @(negedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== baddr) begin
         fails++;
         $display("FAIL collision_next: got v=%b req=%b addr=%h want v=0 req=1 addr=%h", out_valid, imem_req, imem_addr, baddr);
      end
      wait_valid("collision", 30, found);
      if (found) begin
         tests++;
         if (pc !== baddr + STEP || instruction !== mem[baddr[9:2]]) begin
            fails++;
            $display("FAIL collision_target: got pc=%h inst=%h want pc=%h inst=%h", pc, instruction, baddr + STEP, mem[baddr[9:2]]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, a2;
      bit          found;
      lat_min = 2; lat_max = 2;
      repeat (6) @(negedge clk);
      a1 = 32'($urandom_range(0, 127)) << 2;
      a2 = 32'($urandom_range(128, 255)) << 2;
      @(posedge clk); #2;
      branch_taken = 1'b1; branch_addr = a1;
      @(posedge clk); #2;
      branch_addr = a2;
      @(posedge clk); #2;
      branch_taken = 1'b0;
      @(negedge clk); #1;
      tests++;
      if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== a2) begin
         fails++;
         $display("FAIL b2b_next: got v=%b req=%b addr=%h want v=0 req=1 addr=%h", out_valid, imem_req, imem_addr, a2);
      end
      wait_valid("b2b", 30, found);
      if (found) begin
         tests++;
         if (pc !== a2 + STEP || instruction !== mem[a2[9:2]]) begin
            fails++;
            $display("FAIL b2b_target: got pc=%h inst=%h want pc=%h inst=%h", pc, instruction, a2 + STEP, mem[a2[9:2]]);
         end
      end
   endtask

   task automatic test_random_ready();
      int start, n;
      ready_pct = 50; lat_min = 1; lat_max = 3;
      start = pops; n = 0;
      while ((pops - start) < 100 && n < 4000) begin
         @(posedge clk); #2;
         freeze       = (int'($urandom_range(0, 99)) < 25);
         branch_taken = (int'($urandom_range(0, 99)) < 2);
         branch_addr  = 32'($urandom_range(0, 255)) << 2;
         n++;
      end
      freeze = 1'b0; branch_taken = 1'b0;
      tests++;
      if ((pops - start) < 100) begin
         fails++;
         $display("FAIL random_progress: got %0d words delivered want 100", pops - start);
      end
      ready_pct = 100; lat_min = 1; lat_max = 1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_mid_reset();
      bit found;
      wait_valid("pre_reset", 30, found);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || imem_req !== 1'b0 || instruction !== '0 || pc !== '0) begin
         fails++;
         $display("FAIL async_reset: got v=%b req=%b inst=%h pc=%h want 0", out_valid, imem_req, instruction, pc);
      end
      #20;
      @(posedge clk); #2;
      rst = 1'b0;
      wait_valid("restart", 30, found);
      if (found) begin
         tests++;
         if (pc !== RPC + STEP || instruction !== mem[RPC[9:2]] || first_valid_cyc !== first_acc_cyc + 2) begin
            fails++;
            $display("FAIL restart: got pc=%h inst=%h lat=%0d want pc=%h inst=%h lat=2",
                     pc, instruction, first_valid_cyc - first_acc_cyc, RPC + STEP, mem[RPC[9:2]]);
         end
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      test_reset();
      test_sequential();
      test_freeze();
      test_branch();
      test_branch_collision();
      test_back_to_back();
      test_random_ready();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
